// File: rtl/m_store_buffer_pkg.sv
// rtl/m_store_buffer_pkg.sv - shared constants and entry type for the store buffer
package m_store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int BE_W     = 4;
  localparam int WOFF_W   = 2;
  localparam int WADDR_W  = 32 - WOFF_W;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [31:0]        wdata;
    logic [BE_W-1:0]    be;
    logic [31:0]        pc;
  } sb_entry_t;

  // Word address: byte address with the in-word offset stripped.
  function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] a);
    return a[31:WOFF_W];
  endfunction

endpackage

// File: rtl/m_sb_fwd_sel.sv
// rtl/m_sb_fwd_sel.sv - per-byte youngest-match store-to-load forwarding select
module m_sb_fwd_sel
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]              ent_valid,
  input  logic [DEPTH-1:0][WADDR_W-1:0] ent_waddr,
  input  logic [DEPTH-1:0][BE_W-1:0]    ent_be,
  input  logic [DEPTH-1:0][31:0]        ent_wdata,
  input  logic [PTR_W-1:0]              head,
  input  logic [WADDR_W-1:0]            ld_waddr,
  output logic [31:0]                   fwd_data,
  output logic [BE_W-1:0]               fwd_mask
);

  logic [PTR_W-1:0] idx;

  // Walk entries oldest (head) to youngest (tail-1); a later hit overwrites
  // an earlier one, so each lane ends up holding the youngest matching byte.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      for (int i = 0; i < BE_W; i++) begin
        if (ent_valid[idx] && (ent_waddr[idx] == ld_waddr) && ent_be[idx][i]) begin
          fwd_mask[i]       = 1'b1;
          fwd_data[8*i +: 8] = ent_wdata[idx][8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/m_store_buffer.sv
// rtl/m_store_buffer.sv - posted-write store FIFO with store-to-load forwarding
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  input  logic [BE_W-1:0]  st_be,
  input  logic [31:0]      st_pc,
  output logic             st_ready,
  input  logic [31:0]      ld_addr,
  output logic [31:0]      fwd_data,
  output logic [BE_W-1:0]  fwd_mask,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [BE_W-1:0]  dm_be,
  output logic [31:0]      dm_pc,
  input  logic             dm_ready,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  sb_entry_t        ent_q [DEPTH];

  logic enq;
  logic deq;

  logic [DEPTH-1:0]              ent_valid;
  logic [DEPTH-1:0][WADDR_W-1:0] ent_waddr;
  logic [DEPTH-1:0][BE_W-1:0]    ent_be;
  logic [DEPTH-1:0][31:0]        ent_wdata;
  logic [PTR_W-1:0]              ent_age [DEPTH];

  // Ready/empty come from registered count only, so no path from dm_ready.
  assign st_ready = (count != CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign enq      = st_valid && st_ready;
  assign dm_we    = !empty;
  assign deq      = dm_we && dm_ready;

  assign dm_addr  = {ent_q[head].waddr, {WOFF_W{1'b0}}};
  assign dm_wdata = ent_q[head].wdata;
  assign dm_be    = ent_q[head].be;
  assign dm_pc    = ent_q[head].pc;

  // Pointer and occupancy state; reset drops every buffered store at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; validity is defined by head/count, so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_q[tail] <= '{waddr: word_addr(st_addr), wdata: st_wdata,
                       be: st_be, pc: st_pc};
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  for (genvar j = 0; j < DEPTH; j++) begin : g_ent
    assign ent_age[j]   = PTR_W'(j) - head;
    assign ent_valid[j] = (CNT_W'(ent_age[j]) < count);
    assign ent_waddr[j] = ent_q[j].waddr;
    assign ent_be[j]    = ent_q[j].be;
    assign ent_wdata[j] = ent_q[j].wdata;
  end

  m_sb_fwd_sel #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_sel (
    .ent_valid (ent_valid),
    .ent_waddr (ent_waddr),
    .ent_be    (ent_be),
    .ent_wdata (ent_wdata),
    .head      (head),
    .ld_waddr  (word_addr(ld_addr)),
    .fwd_data  (fwd_data),
    .fwd_mask  (fwd_mask)
  );

endmodule

// File: tb/tb_m_store_buffer.sv
// tb/tb_m_store_buffer.sv - self-checking bench for m_store_buffer
module tb_m_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        dm_ready;
  logic        empty;
  logic [2:0]  count;

  m_store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .st_pc    (st_pc),
    .st_ready (st_ready),
    .ld_addr  (ld_addr),
    .fwd_data (fwd_data),
    .fwd_mask (fwd_mask),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .dm_pc    (dm_pc),
    .dm_ready (dm_ready),
    .empty    (empty),
    .count    (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] pc;
    logic [31:0] ld;
    logic        dr;
    logic        rdy;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic [31:0] dpc;
    logic [2:0]  cnt;
    logic [3:0]  fm;
    logic [31:0] fd;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  function automatic vec_t mk(
    input logic sv, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
    input logic [31:0] pc, input logic [31:0] ld, input logic dr,
    input logic rdy, input logic we, input logic [31:0] daddr, input logic [31:0] dwd,
    input logic [3:0] dbe, input logic [31:0] dpc, input logic [2:0] cnt,
    input logic [3:0] fm, input logic [31:0] fd);
    vec_t v;
    v.sv = sv; v.addr = addr; v.wd = wd; v.be = be; v.pc = pc; v.ld = ld; v.dr = dr;
    v.rdy = rdy; v.we = we; v.daddr = daddr; v.dwd = dwd; v.dbe = dbe; v.dpc = dpc;
    v.cnt = cnt; v.fm = fm; v.fd = fd;
    return v;
  endfunction

  task automatic check_idle_reset(input string tag);
    chk({tag, " empty"},    32'(empty),    32'd1);
    chk({tag, " count"},    32'(count),    32'd0);
    chk({tag, " st_ready"}, 32'(st_ready), 32'd1);
    chk({tag, " dm_we"},    32'(dm_we),    32'd0);
    chk({tag, " fwd_mask"}, 32'(fwd_mask), 32'd0);
  endtask

  initial begin
    // Each row: inputs driven this cycle, outputs expected before the next edge.
    tv[0]  = mk(1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h3008, 32'h0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 32'h10, 1, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h3008, 1, 4'hF, 32'hDEADBEEF);
    tv[2]  = mk(0, 0, 0, 0, 0, 32'h10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[3]  = mk(1, 32'h100, 32'hA0, 4'hF, 32'h4000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[4]  = mk(1, 32'h104, 32'hA1, 4'hF, 32'h4004, 0, 0, 1, 1, 32'h100, 32'hA0, 4'hF, 32'h4000, 1, 0, 0);
    tv[5]  = mk(1, 32'h108, 32'hA2, 4'hF, 32'h4008, 0, 0, 1, 1, 32'h100, 32'hA0, 4'hF, 32'h4000, 2, 0, 0);
    tv[6]  = mk(1, 32'h10C, 32'hA3, 4'hF, 32'h400C, 0, 0, 1, 1, 32'h100, 32'hA0, 4'hF, 32'h4000, 3, 0, 0);
    tv[7]  = mk(1, 32'h110, 32'hA4, 4'hF, 32'h4010, 0, 0, 0, 1, 32'h100, 32'hA0, 4'hF, 32'h4000, 4, 0, 0);
    tv[8]  = mk(1, 32'h110, 32'hA4, 4'hF, 32'h4010, 32'h10C, 0, 0, 1, 32'h100, 32'hA0, 4'hF, 32'h4000, 4, 4'hF, 32'hA3);
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h100, 32'hA0, 4'hF, 32'h4000, 4, 0, 0);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h104, 32'hA1, 4'hF, 32'h4004, 3, 0, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h108, 32'hA2, 4'hF, 32'h4008, 2, 0, 0);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h10C, 32'hA3, 4'hF, 32'h400C, 1, 0, 0);
    tv[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[14] = mk(1, 32'h20, 32'h11223344, 4'h3, 32'h5000, 32'h22, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[15] = mk(1, 32'h20, 32'hAABBCCDD, 4'h6, 32'h5004, 32'h22, 0, 1, 1, 32'h20, 32'h11223344, 4'h3, 32'h5000, 1, 4'h3, 32'h00003344);
    tv[16] = mk(1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h5008, 32'h22, 0, 1, 1, 32'h20, 32'h11223344, 4'h3, 32'h5000, 2, 4'h7, 32'h00BBCC44);
    tv[17] = mk(0, 0, 0, 0, 0, 32'h24, 0, 1, 1, 32'h20, 32'h11223344, 4'h3, 32'h5000, 3, 0, 0);
    tv[18] = mk(0, 0, 0, 0, 0, 32'h20, 0, 1, 1, 32'h20, 32'h11223344, 4'h3, 32'h5000, 3, 4'h7, 32'h00BBCC44);
    tv[19] = mk(0, 0, 0, 0, 0, 32'h20, 1, 1, 1, 32'h20, 32'h11223344, 4'h3, 32'h5000, 3, 4'h7, 32'h00BBCC44);
    tv[20] = mk(0, 0, 0, 0, 0, 32'h20, 1, 1, 1, 32'h20, 32'hAABBCCDD, 4'h6, 32'h5004, 2, 4'h6, 32'h00BBCC00);
    tv[21] = mk(0, 0, 0, 0, 0, 32'h20, 1, 1, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h5008, 1, 0, 0);
    tv[22] = mk(0, 0, 0, 0, 0, 32'h20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
    st_pc = '0; ld_addr = '0; dm_ready = 1'b0;

    @(negedge clk); #1;
    check_idle_reset("rst_held");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_reset("rst_released");

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      st_valid = tv[r].sv; st_addr = tv[r].addr; st_wdata = tv[r].wd;
      st_be = tv[r].be; st_pc = tv[r].pc; ld_addr = tv[r].ld; dm_ready = tv[r].dr;
      #1;
      chk($sformatf("r%0d st_ready", r), 32'(st_ready), 32'(tv[r].rdy));
      chk($sformatf("r%0d dm_we", r),    32'(dm_we),    32'(tv[r].we));
      chk($sformatf("r%0d count", r),    32'(count),    32'(tv[r].cnt));
      chk($sformatf("r%0d empty", r),    32'(empty),    32'(tv[r].cnt == 3'd0));
      chk($sformatf("r%0d fwd_mask", r), 32'(fwd_mask), 32'(tv[r].fm));
      chk($sformatf("r%0d fwd_data", r), fwd_data,      tv[r].fd);
      if (tv[r].we) begin
        chk($sformatf("r%0d dm_addr", r),  dm_addr,       tv[r].daddr);
        chk($sformatf("r%0d dm_wdata", r), dm_wdata,      tv[r].dwd);
        chk($sformatf("r%0d dm_be", r),    32'(dm_be),    32'(tv[r].dbe));
        chk($sformatf("r%0d dm_pc", r),    dm_pc,         tv[r].dpc);
      end
    end

    // Overlapped enqueue/dequeue at count=2; pointers wrap past index 3.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      st_valid = (c < 8); st_addr = 32'h200 + 32'(4 * c); st_wdata = 32'hD00 + 32'(c);
      st_be = 4'hF; st_pc = 32'h6000 + 32'(4 * c); ld_addr = '0; dm_ready = (c >= 2);
      #1;
      chk($sformatf("ovl c%0d count", c), 32'(count),
          (c == 0) ? 32'd0 : (c == 1 || c == 9) ? 32'd1 : 32'd2);
      if (c >= 2) begin
        chk($sformatf("ovl c%0d dm_we", c),    32'(dm_we), 32'd1);
        chk($sformatf("ovl c%0d dm_wdata", c), dm_wdata,   32'hD00 + 32'(c - 2));
        chk($sformatf("ovl c%0d dm_addr", c),  dm_addr,    32'h200 + 32'(4 * (c - 2)));
      end
    end
    @(negedge clk);
    st_valid = 1'b0; dm_ready = 1'b0;
    #1;
    chk("ovl end count", 32'(count), 32'd0);
    chk("ovl end empty", 32'(empty), 32'd1);

    // Reset asserted mid-cycle while three stores are pending.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      st_valid = 1'b1; st_addr = 32'h300; st_wdata = 32'hE00 + 32'(k);
      st_be = 4'hF; st_pc = 32'h7000; ld_addr = 32'h300; dm_ready = 1'b0;
    end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("mid count pre", 32'(count), 32'd3);
    chk("mid dm_we pre", 32'(dm_we), 32'd1);
    chk("mid fwd_mask pre", 32'(fwd_mask), 32'hF);
    chk("mid fwd_data pre", fwd_data, 32'hE02);
    #2;
    rst = 1'b0;
    #1;
    check_idle_reset("mid_rst");
    @(negedge clk);
    rst = 1'b1; dm_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("post_rst c%0d dm_we", k), 32'(dm_we), 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
